// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial pattern detector with Moore match flag
module seq_detector_prog #(
  parameter int unsigned                MAX_LEN     = 8,
  parameter int unsigned                LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int unsigned                CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]         DEF_PATTERN = 8'b0000_1011,
  parameter int unsigned                DEF_LEN     = 4,
  parameter bit                         DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0]   MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN:0]   ONE_W     = (MAX_LEN + 1)'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN:0]   mask_wide;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               cfg_ok;

  // Mask is built one bit wider so a full-length pattern does not overflow the shift.
  always_comb begin
    hist_n    = {hist_q[MAX_LEN-2:0], x};
    fill_n    = (fill_q >= MAX_LEN_W) ? MAX_LEN_W : fill_q + 1'b1;
    mask_wide = (ONE_W << len_q) - ONE_W;
    mask      = mask_wide[MAX_LEN-1:0];
    hit       = (fill_n >= len_q) && ((hist_n & mask) == (pattern_q & mask));
    cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_W);
  end

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    z_d       = 1'b0;
    cfg_err_d = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = hist_n;
      // Non-overlapping mode forgets the matched bits by emptying the fill count.
      fill_d = (hit && !overlap_q) ? '0 : fill_n;
      z_d    = hit;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (z_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - directed vector bench for seq_detector_prog
module tb_seq_detector_prog;

  typedef struct {
    logic        rst;
    logic        en;
    logic        x;
    logic        ld;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ov;
    logic        clr;
    logic        ez;
    logic [15:0] ecnt;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, x, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        z, cfg_err;
  logic [15:0] match_cnt;

  logic        rst_b, en_b, x_b, load_b, ov_b, clr_b;
  logic [7:0]  pat_b;
  logic [3:0]  len_b;
  logic        z_b, err_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detector_prog #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .x(x_b), .cfg_load(load_b),
    .cfg_pattern(pat_b), .cfg_len(len_b), .cfg_overlap(ov_b),
    .cnt_clr(clr_b), .z(z_b), .match_cnt(cnt_b), .cfg_err(err_b)
  );

  function automatic vec_t mk(logic r, logic e, logic xi, logic l, logic [7:0] p,
                              logic [3:0] n, logic o, logic c,
                              logic ez, logic [15:0] ec, logic ee);
    vec_t v;
    v.rst = r; v.en = e; v.x = xi; v.ld = l; v.pat = p; v.len = n; v.ov = o;
    v.clr = c; v.ez = ez; v.ecnt = ec; v.eerr = ee;
    return v;
  endfunction

  task automatic smp(logic xi, logic ez, logic [15:0] ec, logic c = 1'b0);
    vecs.push_back(mk(0, 1, xi, 0, 8'h00, 4'd0, 0, c, ez, ec, 0));
  endtask

  task automatic idle(logic xi, logic [15:0] ec);
    vecs.push_back(mk(0, 0, xi, 0, 8'h00, 4'd0, 0, 0, 0, ec, 0));
  endtask

  task automatic load(logic [7:0] p, logic [3:0] n, logic o, logic c,
                      logic [15:0] ec, logic ee);
    vecs.push_back(mk(0, 1, 1, 1, p, n, o, c, 0, ec, ee));
  endtask

  task automatic chk(string name, int idx, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic step_b(logic r, logic e, logic xi, logic l, logic [7:0] p,
                        logic [3:0] n, logic o, int idx, logic ez, logic [1:0] ec);
    rst_b = r; en_b = e; x_b = xi; load_b = l; pat_b = p; len_b = n; ov_b = o; clr_b = 0;
    @(posedge clk); #1;
    chk("b_z", idx, {15'd0, z_b}, {15'd0, ez});
    chk("b_cnt", idx, {14'd0, cnt_b}, {14'd0, ec});
  endtask

  initial begin
    rst_b = 1; en_b = 0; x_b = 0; load_b = 0; pat_b = 0; len_b = 0; ov_b = 0; clr_b = 0;

    // reset defaults, overlapping 1011
    vecs.push_back(mk(1, 1, 1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0));
    smp(1, 0, 0); smp(0, 0, 0); smp(1, 0, 0); smp(1, 1, 1);
    smp(0, 0, 1); smp(1, 0, 1); smp(1, 1, 2);
    idle(1, 2);
    // non-overlapping 1011, count cleared by the load cycle
    load(8'b0000_1011, 4'd4, 0, 1, 0, 0);
    smp(1, 0, 0); smp(0, 0, 0); smp(1, 0, 0); smp(1, 1, 1);
    smp(0, 0, 1); smp(1, 0, 1); smp(1, 0, 1);
    smp(1, 0, 1); smp(0, 0, 1); smp(1, 0, 1); smp(1, 1, 0, 1'b1);
    // 111 overlapping then non-overlapping
    load(8'b0000_0111, 4'd3, 1, 0, 0, 0);
    smp(1, 0, 0); smp(1, 0, 0); smp(1, 1, 1); smp(1, 1, 2); smp(1, 1, 3);
    load(8'b0000_0111, 4'd3, 0, 0, 3, 0);
    smp(1, 0, 3); smp(1, 0, 3); smp(1, 1, 4); smp(1, 0, 4); smp(1, 0, 4);
    // full-length pattern with en gaps
    load(8'b1010_0111, 4'd8, 1, 0, 4, 0);
    smp(1, 0, 4); idle(1, 4); smp(0, 0, 4); idle(1, 4);
    smp(1, 0, 4); idle(0, 4); smp(0, 0, 4); idle(1, 4);
    smp(0, 0, 4); idle(1, 4); smp(1, 0, 4); idle(0, 4);
    smp(1, 0, 4); idle(0, 4); smp(1, 1, 5); idle(1, 5);
    // rejected loads keep the 1011 config and history
    load(8'b0000_1011, 4'd4, 1, 0, 5, 0);
    smp(1, 0, 5); smp(0, 0, 5);
    load(8'b0000_0001, 4'd0, 1, 0, 5, 1);
    load(8'b0000_0001, 4'd9, 1, 0, 5, 1);
    smp(1, 0, 5); smp(1, 1, 6);
    idle(0, 6);
    // reset mid-sequence discards partial history
    smp(1, 0, 6); smp(0, 0, 6); smp(1, 0, 6);
    vecs.push_back(mk(1, 1, 1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0));
    smp(1, 0, 0); smp(0, 0, 0); smp(1, 0, 0); smp(1, 1, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; x = vecs[i].x; cfg_load = vecs[i].ld;
      cfg_pattern = vecs[i].pat; cfg_len = vecs[i].len; cfg_overlap = vecs[i].ov;
      cnt_clr = vecs[i].clr;
      @(posedge clk); #1;
      if (i == 0) rst_b = 0;
      chk("z", i, {15'd0, z}, {15'd0, vecs[i].ez});
      chk("match_cnt", i, match_cnt, vecs[i].ecnt);
      chk("cfg_err", i, {15'd0, cfg_err}, {15'd0, vecs[i].eerr});
    end

    // saturating 2-bit counter with single-bit pattern, back-to-back matches
    step_b(0, 0, 0, 1, 8'b0000_0001, 4'd1, 1, 0, 0, 0);
    step_b(0, 1, 1, 0, 8'h00, 4'd0, 0, 1, 1, 1);
    step_b(0, 1, 1, 0, 8'h00, 4'd0, 0, 2, 1, 2);
    step_b(0, 1, 1, 0, 8'h00, 4'd0, 0, 3, 1, 3);
    step_b(0, 1, 1, 0, 8'h00, 4'd0, 0, 4, 1, 3);
    step_b(0, 1, 1, 0, 8'h00, 4'd0, 0, 5, 1, 3);
    step_b(0, 1, 0, 0, 8'h00, 4'd0, 0, 6, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector with a Moore output, one bit per enabled clock.
- Generalises the fixed-pattern detector family:
  - pattern and length are loaded at runtime, up to MAX_LEN bits;
  - overlapping or non-overlapping mode is selectable;
  - a saturating match counter is included.
- Sits on a serial input stream and provides match flags and counts to control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN)+1, width of the length field.
- CNT_W, 16, match counter width.
- DEF_PATTERN, 8'b0000_1011, reset pattern. Right-aligned; pattern[len-1] is the first bit received.
- DEF_LEN, 4, reset pattern length.
- DEF_OVERLAP, 1, reset mode (1 = overlapping).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, sample x this cycle.
- x, input, 1, serial data bit.
- cfg_load, input, 1, load cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, input, MAX_LEN, pattern to load (right-aligned).
- cfg_len, input, LEN_W, pattern length to load.
- cfg_overlap, input, 1, 1 = overlapping mode, 0 = non-overlapping mode.
- cnt_clr, input, 1, clear match_cnt.
- z, output, 1, registered match flag.
- match_cnt, output, CNT_W, saturating count of matches.
- cfg_err, output, 1, one-cycle pulse when a load is rejected.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst), sampled at the rising edge of clk.
- Reset values:
  - pattern = DEF_PATTERN, len = DEF_LEN, overlap = DEF_OVERLAP;
  - hist = 0, fill = 0;
  - z = 0, match_cnt = 0, cfg_err = 0.
  - Reset overrides all other inputs, including mid-sequence: the partial history is discarded.
- State registers:
  - hist[MAX_LEN-1:0] shift register; newest bit in hist[0].
  - fill[LEN_W-1:0]: number of valid history bits, saturating at MAX_LEN.
- Priority per edge: rst > cfg_load > en.
- Config load (cfg_load=1):
  - If 1 <= cfg_len <= MAX_LEN: latch pattern, len and overlap; set hist=0, fill=0, z=0.
  - The x bit is discarded that cycle even if en=1.
  - If cfg_len == 0 or cfg_len > MAX_LEN: config and history are unchanged, z=0, cfg_err=1 for one cycle.
  - cfg_err is 0 on every other cycle.
- Sample (en=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, MAX_LEN).
  - hit = (fill_n >= len) && (hist_n[len-1:0] == pattern[len-1:0]). Bits at or above len are ignored.
  - z <= hit.
  - On hit in overlapping mode: hist and fill update normally, so the matched bits can start the next match.
  - On hit in non-overlapping mode: hist <= hist_n but fill <= 0, so the next match needs len fresh bits.
- Idle (en=0, cfg_load=0): hist and fill hold; z <= 0.
- Latency: z is high in the clock cycle after the edge that sampled the final pattern bit.
  - z is high for exactly one cycle per match.
  - Back-to-back matches give consecutive z cycles (e.g. pattern "1", or "11" with overlap).
- Counter update:
  - match_cnt increments on each edge that sets z=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 sets match_cnt=0 and takes priority over a simultaneous increment.
  - cfg_load does not clear match_cnt.
- Width rules:
  - All length compares are done at LEN_W bits.
  - The pattern compare is masked: mask = (1<<len)-1, computed at MAX_LEN+1 bits so len = MAX_LEN does not overflow.

Test Plan:
1. Reset defaults (1011, overlap); x stream 1,0,1,1,0,1,1 with en=1 -> z high in the cycles after bits 4 and 7; match_cnt=2.
2. Load cfg_pattern=1011, cfg_len=4, cfg_overlap=0; same stream -> z high only after bit 4; match_cnt=1. Then cnt_clr together with a hit edge -> match_cnt=0.
3. Load pattern 111, len 3, overlap=1; x=1 for 5 cycles -> z high after bits 3, 4 and 5; 3 counts. Repeat with overlap=0 -> z high after bit 3 only.
4. Load pattern 8'b1010_0111, len 8; send it with en toggling low between bits -> z high once after the 8th enabled bit; z low during en=0 cycles.
5. cfg_load with cfg_len=0, then again with cfg_len=9 -> cfg_err pulses each time; the 1011 config still detects correctly.
6. CNT_W=2: 5 matches -> match_cnt sticks at 3. Assert rst after bits 1,0,1 of 1011 -> next 1 gives no match; full 1011 after reset -> match.
